// File: rtl/cpu_lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: access-size encodings and the
// registered request record.
package cpu_lsu_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        is_unsigned;
    } lsu_req_t;

endpackage

// File: rtl/cpu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational so a future cache can reuse it on its own read path.
module cpu_load_align
    import cpu_lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  a_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{a_i, 3'b000} +: 8];
        half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            SIZE_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            SIZE_WORD: data_o = rdata_i;
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/cpu_lsu_ctrl.sv
// Load/store sequencer: registers an execute-stage request, drives the data bus and
// stalls the pipeline until ack, error or watchdog timeout.
module cpu_lsu_ctrl
    import cpu_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p3_request,
    input  logic [31:0] p3_addr,
    input  logic        p3_write,
    input  logic [3:0]  p3_byte_enable,
    input  logic [31:0] p3_wdata,
    input  logic [1:0]  p3_size,
    input  logic        p3_unsigned,
    output logic        bus_request,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_error,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic        p4_load_valid,
    output logic [31:0] p4_load_data,
    output logic        p4_bus_error,
    output logic [31:0] p4_bus_error_addr
);

    typedef enum logic {StIdle, StWait} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [15:0] timer_q, timer_d;
    logic        bus_request_q, bus_request_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        resp, timeout, accept;

    always_comb begin
        resp          = bus_ack | bus_error;
        timeout       = (timer_q == TimeoutLast);
        // A response cycle drops the stall, so execute may hand over the next access.
        accept        = p3_request & ((state_q == StIdle) | ((state_q == StWait) & resp));
        state_d       = state_q;
        req_d         = req_q;
        timer_d       = timer_q;
        bus_request_d = 1'b0;
        err_d         = 1'b0;
        err_addr_d    = err_addr_q;
        mem_stall     = 1'b0;
        p4_load_valid = 1'b0;

        if (state_q == StWait) begin
            mem_stall     = ~resp;
            p4_load_valid = bus_ack & ~bus_error & ~req_q.write;
            if (resp || timeout) begin
                state_d = StIdle;
                if (bus_error || !bus_ack) begin
                    err_d      = 1'b1;
                    err_addr_d = req_q.addr;
                end
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end

        if (accept) begin
            state_d           = StWait;
            timer_d           = 16'd0;
            bus_request_d     = 1'b1;
            req_d.addr        = p3_addr;
            req_d.write       = p3_write;
            req_d.be          = p3_write ? p3_byte_enable : 4'hF;
            req_d.wdata       = p3_wdata;
            req_d.size        = p3_size;
            req_d.is_unsigned = p3_unsigned;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            req_q         <= '0;
            timer_q       <= 16'd0;
            bus_request_q <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            timer_q       <= timer_d;
            bus_request_q <= bus_request_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
        end
    end

    assign bus_request       = bus_request_q;
    assign bus_addr          = {req_q.addr[31:2], 2'b00};
    assign bus_write         = req_q.write;
    assign bus_byte_enable   = req_q.be;
    assign bus_wdata         = req_q.wdata;
    assign p4_bus_error      = err_q;
    assign p4_bus_error_addr = err_addr_q;

    cpu_load_align u_load_align (
        .rdata_i    (bus_rdata),
        .a_i        (req_q.addr[1:0]),
        .size_i     (req_q.size),
        .unsigned_i (req_q.is_unsigned),
        .data_o     (p4_load_data)
    );

endmodule
